// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit that owns the HI/LO register pair.
// Define MDU_FAST_MUL_EN to make MULT/MULTU write HI/LO in the accept cycle.
module mult_div_unit #(
    parameter int MUL_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid_in,
    input  logic [2:0]  op_type_in,
    input  logic [31:0] src_a_in,
    input  logic [31:0] src_b_in,
    input  logic        cancel_in,
    output logic        op_ready_out,
    output logic [31:0] mult_div_res_out,
    output logic        mult_div_accessible_out,
    output logic        busy_out,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MFHI  = 3'd6;
    localparam logic [2:0] OP_MFLO  = 3'd7;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        sgn_q, sgn_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        res_sel_q, res_sel_d;

    logic        accept;
    logic [31:0] b_mag;
    logic [32:0] shifted;
    logic [32:0] diff;

    // Operands are widened to the full product width so the signed multiply
    // sign-extends them; only the low 64 bits are architecturally visible.
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic signed [65:0] ae;
        logic signed [65:0] be;
        ae = {{34{sgn & a[31]}}, a};
        be = {{34{sgn & b[31]}}, b};
        return 64'(ae * be);
    endfunction

    assign op_ready_out            = !cancel_in && (state_q == S_IDLE || op_type_in[2:1] == 2'b11);
    assign accept                  = op_valid_in && op_ready_out;
    assign busy_out                = (state_q != S_IDLE);
    assign mult_div_accessible_out = (state_q == S_IDLE);
    assign mult_div_res_out        = res_sel_q ? hi_q : lo_q;
    assign hi_out                  = hi_q;
    assign lo_out                  = lo_q;
    assign b_mag                   = (sgn_q && b_q[31]) ? 32'(-b_q) : b_q;

    // NOTE: every variable gets its default before any branch, so no path
    // through this block can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        sgn_d     = sgn_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        res_sel_d = res_sel_q;
        shifted   = {rem_q, quo_q[31]};
        diff      = shifted - {1'b0, b_mag};

        if (cancel_in) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_MUL: begin
                    if (cnt_q == 5'(MUL_CYCLES - 1)) begin
                        {hi_d, lo_d} = mul64(a_q, b_q, sgn_q);
                        state_d      = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                S_DIV: begin
                    // Restoring step: keep the trial difference only when it did not borrow.
                    if (!diff[32]) begin
                        rem_d = diff[31:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = shifted[31:0];
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                    if (cnt_q == 5'd31) state_d = S_FIX;
                    else                cnt_d   = cnt_q + 5'd1;
                end
                S_FIX: begin
                    if (b_q == 32'd0) begin
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = a_q;
                    end else begin
                        lo_d = (sgn_q && (a_q[31] ^ b_q[31])) ? 32'(-quo_q) : quo_q;
                        hi_d = (sgn_q && a_q[31]) ? 32'(-rem_q) : rem_q;
                    end
                    state_d = S_IDLE;
                end
                default: ;
            endcase

            if (accept) begin
                unique case (op_type_in)
                    OP_MULT, OP_MULTU: begin
`ifdef MDU_FAST_MUL_EN
                        {hi_d, lo_d} = mul64(src_a_in, src_b_in, ~op_type_in[0]);
`else
                        state_d = S_MUL;
                        cnt_d   = '0;
                        a_d     = src_a_in;
                        b_d     = src_b_in;
                        sgn_d   = ~op_type_in[0];
`endif
                    end
                    OP_DIV, OP_DIVU: begin
                        state_d = S_DIV;
                        cnt_d   = '0;
                        a_d     = src_a_in;
                        b_d     = src_b_in;
                        sgn_d   = ~op_type_in[0];
                        rem_d   = '0;
                        quo_d   = (!op_type_in[0] && src_a_in[31]) ? 32'(-src_a_in) : src_a_in;
                    end
                    OP_MTHI: hi_d      = src_a_in;
                    OP_MTLO: lo_d      = src_a_in;
                    OP_MFHI: res_sel_d = 1'b1;
                    OP_MFLO: res_sel_d = 1'b0;
                    default: ;
                endcase
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sgn_q     <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            res_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sgn_q     <= sgn_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            res_sel_q <= res_sel_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit; expected values are hand-computed.
module tb_mult_div_unit;

    localparam int MUL_CYCLES = 3;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = MUL_CYCLES;
`endif

    logic        clk;
    logic        rst;
    logic        op_valid_in;
    logic [2:0]  op_type_in;
    logic [31:0] src_a_in;
    logic [31:0] src_b_in;
    logic        cancel_in;
    logic        op_ready_out;
    logic [31:0] mult_div_res_out;
    logic        mult_div_accessible_out;
    logic        busy_out;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int tests = 0;
    int fails = 0;

    mult_div_unit #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .op_valid_in             (op_valid_in),
        .op_type_in              (op_type_in),
        .src_a_in                (src_a_in),
        .src_b_in                (src_b_in),
        .cancel_in               (cancel_in),
        .op_ready_out            (op_ready_out),
        .mult_div_res_out        (mult_div_res_out),
        .mult_div_accessible_out (mult_div_accessible_out),
        .busy_out                (busy_out),
        .hi_out                  (hi_out),
        .lo_out                  (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one op, confirms it is ready, and returns 1 time unit after the accept edge.
    task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        op_type_in  = op;
        src_a_in    = a;
        src_b_in    = b;
        op_valid_in = 1'b1;
        #1;
        check({tag, " ready"}, 32'(op_ready_out), 32'd1);
        @(posedge clk); #1;
        op_valid_in = 1'b0;
    endtask

    // Counts sampled busy cycles, starting just after the accept edge.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy_out && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        rst         = 1'b1;
        op_valid_in = 1'b0;
        op_type_in  = 3'd0;
        src_a_in    = '0;
        src_b_in    = '0;
        cancel_in   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst hi", hi_out, 32'h0);
        check("rst lo", lo_out, 32'h0);
        check("rst busy", 32'(busy_out), 32'd0);
        check("rst acc", 32'(mult_div_accessible_out), 32'd1);
        check("rst res", mult_div_res_out, 32'h0);
        check("rst ready", 32'(op_ready_out), 32'd1);
        rst = 1'b0;

        issue("mult", 3'd0, 32'hFFFF_FFFF, 32'h2);
        wait_idle(n);
        check("mult lat", n, MUL_LAT);
        check("mult hi", hi_out, 32'hFFFF_FFFF);
        check("mult lo", lo_out, 32'hFFFF_FFFE);

        issue("multu", 3'd1, 32'hFFFF_FFFF, 32'h2);
        wait_idle(n);
        check("multu lat", n, MUL_LAT);
        check("multu hi", hi_out, 32'h1);
        check("multu lo", lo_out, 32'hFFFF_FFFE);

        issue("div neg", 3'd2, 32'hFFFF_FFF9, 32'h2);
        wait_idle(n);
        check("div neg busy cycles", n, 33);
        check("div neg lo", lo_out, 32'hFFFF_FFFD);
        check("div neg hi", hi_out, 32'hFFFF_FFFF);

        issue("divu", 3'd3, 32'd100, 32'd7);
        wait_idle(n);
        check("divu lo", lo_out, 32'd14);
        check("divu hi", hi_out, 32'd2);

        issue("divu0", 3'd3, 32'h1234_5678, 32'h0);
        wait_idle(n);
        check("divu0 busy cycles", n, 33);
        check("divu0 lo", lo_out, 32'hFFFF_FFFF);
        check("divu0 hi", hi_out, 32'h1234_5678);

        issue("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        check("div ovf lo", lo_out, 32'h8000_0000);
        check("div ovf hi", hi_out, 32'h0);

        // MFLO accepted while a divide is in flight, then an MTHI that must stall.
        issue("divu bg", 3'd3, 32'd100, 32'd7);
        issue("mflo busy", 3'd7, 32'h0, 32'h0);
        check("mflo acc low", 32'(mult_div_accessible_out), 32'd0);
        op_type_in  = 3'd4;
        src_a_in    = 32'hDEAD_BEEF;
        op_valid_in = 1'b1;
        #1;
        check("mthi stalled", 32'(op_ready_out), 32'd0);
        k = 0;
        while (!op_ready_out && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("mthi stall cycles", k, 32);
        check("mflo acc high", 32'(mult_div_accessible_out), 32'd1);
        check("mflo res", mult_div_res_out, 32'd14);
        check("mflo hi before mthi", hi_out, 32'd2);
        @(posedge clk); #1;
        op_valid_in = 1'b0;
        check("mthi hi", hi_out, 32'hDEAD_BEEF);
        check("mthi busy", 32'(busy_out), 32'd0);

        issue("mfhi", 3'd6, 32'h0, 32'h0);
        check("mfhi res", mult_div_res_out, 32'hDEAD_BEEF);

        issue("mtlo", 3'd5, 32'hA5A5_A5A5, 32'h0);
        check("mtlo lo", lo_out, 32'hA5A5_A5A5);
        check("mtlo busy", 32'(busy_out), 32'd0);

        // Cancel mid-divide together with an MFLO that must not be accepted.
        issue("div cancel", 3'd2, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        cancel_in   = 1'b1;
        op_type_in  = 3'd7;
        op_valid_in = 1'b1;
        #1;
        check("cancel ready", 32'(op_ready_out), 32'd0);
        @(posedge clk); #1;
        cancel_in   = 1'b0;
        op_valid_in = 1'b0;
        check("cancel busy", 32'(busy_out), 32'd0);
        check("cancel lo kept", lo_out, 32'hA5A5_A5A5);
        check("cancel hi kept", hi_out, 32'hDEAD_BEEF);
        check("cancel res_sel kept", mult_div_res_out, 32'hDEAD_BEEF);

        cancel_in   = 1'b1;
        op_type_in  = 3'd0;
        src_a_in    = 32'd2;
        src_b_in    = 32'd3;
        op_valid_in = 1'b1;
        @(posedge clk); #1;
        cancel_in   = 1'b0;
        op_valid_in = 1'b0;
        check("cancel mult busy", 32'(busy_out), 32'd0);
        check("cancel mult lo", lo_out, 32'hA5A5_A5A5);

        issue("mult rst", 3'd0, 32'd5, 32'd6);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mult rst hi", hi_out, 32'h0);
        check("mult rst lo", lo_out, 32'h0);
        check("mult rst busy", 32'(busy_out), 32'd0);
        check("mult rst acc", 32'(mult_div_accessible_out), 32'd1);
        check("mult rst res", mult_div_res_out, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        issue("mtlo pre", 3'd5, 32'h11, 32'h0);
        issue("div rst", 3'd2, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        check("div rst pre busy", 32'(busy_out), 32'd1);
        rst = 1'b1;
        #1;
        check("div rst lo", lo_out, 32'h0);
        check("div rst busy", 32'(busy_out), 32'd0);
        check("div rst acc", 32'(mult_div_accessible_out), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Multiply followed by a divide in the first idle cycle.
        issue("mult 3x4", 3'd0, 32'd3, 32'd4);
        wait_idle(n);
        check("mult 3x4 lat", n, MUL_LAT);
        check("mult 3x4 lo", lo_out, 32'd12);
        check("mult 3x4 hi", hi_out, 32'd0);
        issue("b2b divu", 3'd3, 32'd9, 32'd2);
        check("b2b busy", 32'(busy_out), 32'd1);
        wait_idle(n);
        check("b2b cycles", n, 33);
        check("b2b lo", lo_out, 32'd4);
        check("b2b hi", hi_out, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit owning the HI/LO register pair. It sits in the EXE stage, directly upstream of the MEM stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO operations from EXE. It drives the result and result-valid pair that MEM consumes as `mult_div_res_in` / `mult_div_accessible_in` before MEM may retire an MF-type instruction.

## Interface
- `MUL_CYCLES`, default 3: multiply latency in cycles, legal range 1..8.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `op_valid_in` in 1: EXE presents an operation this cycle.
- `op_type_in` in 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
- `src_a_in` in 32: rs operand (dividend / multiplicand / MT data).
- `src_b_in` in 32: rt operand (divisor / multiplier).
- `cancel_in` in 1: flush from exception/redirect.
- `op_ready_out` out 1: operation accepted when `op_valid_in & op_ready_out`.
- `mult_div_res_out` out 32: HI or LO, as selected by the last accepted MF.
- `mult_div_accessible_out` out 1: HI/LO current, so `mult_div_res_out` is valid.
- `busy_out` out 1: multiply or divide in flight.
- `hi_out` out 32: HI register, for debug/trace.
- `lo_out` out 32: LO register, for debug/trace.

## Operation
- **FSM states:** IDLE, MUL, DIV, FIX.
  - IDLE→MUL on accepted MULT/MULTU.
  - IDLE→DIV on accepted DIV/DIVU.
  - MUL→IDLE when the counter reaches `MUL_CYCLES-1`.
  - DIV→FIX after 32 iterations.
  - FIX→IDLE after one cycle.
  - Any state→IDLE on `cancel_in`.
- **`op_ready_out`** (combinational) = `!cancel_in & (state==IDLE | op_type_in is MFHI/MFLO)`. MT and MUL/DIV operations stall while busy; MF operations are never stalled.
- **MF acceptance:** latches only `res_sel` (1=HI, 0=LO). Then `mult_div_res_out = res_sel ? HI : LO` and `mult_div_accessible_out = (state==IDLE)`.
- **MTHI/MTLO acceptance:** writes `src_a_in` into HI/LO at the accepting edge.
- **Multiply:**
  - Operands are latched at accept.
  - Extended to 33 bits: sign-extended for MULT, zero-extended for MULTU.
  - The product is 66 bits; `{HI,LO}` takes bits [63:0].
- **Divide:**
  - Restoring radix-2 on 32-bit magnitudes. Magnitudes are absolute values for DIV and raw values for DIVU.
  - One quotient bit per DIV cycle.
  - FIX cycle (DIV only): quotient is negated if operand signs differ; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives LO=0x80000000, HI=0.
- **Divide by zero:** LO=0xFFFFFFFF and HI=`src_a_in` as latched, for both DIV and DIVU. The unit still takes the full divide latency.
- **Cancel:**
  - Applies when `cancel_in`=1 while busy.
  - HI/LO are left unchanged and the in-flight result is discarded.
  - Cancel wins over a same-cycle `op_valid_in`: nothing is accepted and `res_sel` is unchanged.

## Timing
- **Reset values:** HI=0, LO=0, state IDLE, `res_sel`=0. Outputs: `busy_out`=0, `mult_div_accessible_out`=1, `mult_div_res_out`=0, `op_ready_out`=1 when `cancel_in`=0.
- **Accept edge T:** `busy_out`=1 from T until state returns to IDLE.
  - Multiply: HI/LO update and `busy_out` falls at edge T+`MUL_CYCLES`.
  - Divide: HI/LO update and `busy_out` falls at edge T+33.
- **MT:** HI/LO visible the cycle after the accept edge; `busy_out` stays 0.
- **MF:**
  - If idle, data is valid the cycle after accept.
  - If issued during MUL/DIV, `mult_div_accessible_out` rises in the same cycle HI/LO take the new value.
- **Reset mid-operation:** asserting `rst` forces all reset values asynchronously; the partial result is discarded.
- **Back-to-back:** a new MUL/DIV can be accepted in the first IDLE cycle after completion.

## Configuration
- **`MDU_FAST_MUL_EN` defined:**
  - MULT/MULTU write HI/LO at the accept edge, like MT.
  - The MUL state is never entered and `busy_out` stays 0 for multiplies.
  - `MUL_CYCLES` is ignored.
- **`MDU_FAST_MUL_EN` not defined:** `MUL_CYCLES`-cycle multiply as specified in Operation/Timing.

## Test plan
- MULT 0xFFFFFFFF×0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE after `MUL_CYCLES` cycles. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV 0xFFFFFFF9 (−7) ÷ 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF, with `busy_out` high for exactly 33 cycles. DIVU 100÷7 -> LO=14, HI=2.
- DIVU 0x12345678÷0 -> LO=0xFFFFFFFF, HI=0x12345678. DIV 0x80000000÷0xFFFFFFFF -> LO=0x80000000, HI=0.
- MFLO issued 1 cycle after DIVU 100÷7 -> accepted immediately. `mult_div_accessible_out`=0 until completion, then 1 with `mult_div_res_out`=14. MTHI during busy -> `op_ready_out`=0 until IDLE.
- Sequence: MTLO 0xA5A5A5A5, then DIV started, `cancel_in` pulsed at cycle 10 -> IDLE next cycle, LO=0xA5A5A5A5 retained. Cancel together with `op_valid_in` -> no acceptance.
- `rst` pulsed mid-MULT and mid-DIV -> HI=LO=0, `busy_out`=0, `mult_div_accessible_out`=1 immediately, without waiting for a clock edge. With `MDU_FAST_MUL_EN`, MULT 3×4 -> LO=12 the next cycle and `busy_out` never asserted.
